// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback on a
// shared datapath with a single memory port.
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   op, funct3_0      opcode and IR bit 12 from the instruction register
//   zero              ALU zero flag for branch resolution
//   mem_ready         memory accepted write / read data valid this cycle
//   pc_write..imm_src datapath controls, combinational from state
//   reg_write         register file write enable
//   illegal           sticky illegal-opcode flag
//   retire_cnt        retired instruction count (wraps)
//   state_o           current state for debug
module multicycle_control_fsm #(
  parameter bit          MEM_HANDSHAKE   = 1'b1,
  parameter bit          BNE_EN          = 1'b1,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       op,
  input  logic             funct3_0,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_req,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_src,
  output logic             reg_write,
  output logic             illegal,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECR     = 4'd6,
    S_EXECI     = 4'd7,
    S_ALUWB     = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_JALR_LINK = 4'd12,
    S_LUI       = 4'd13,
    S_HALT      = 4'd14
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_NOP  = 7'b0000000;

  state_t           state, state_nxt;
  logic             illegal_q;
  logic [CNT_W-1:0] retire_q;
  logic             set_illegal;
  logic             retire;
  logic             ready;

  logic       pc_write_c, adr_src_c, mem_req_c, mem_write_c, ir_write_c, reg_write_c;
  logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, alu_op_c;
  logic [2:0] imm_src_c;

  // With the handshake disabled every memory access completes in one cycle.
  assign ready = mem_ready | ~MEM_HANDSHAKE;

  // State, sticky trap flag and retire counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
      retire_q  <= '0;
    end else begin
      state <= state_nxt;
      if (set_illegal) illegal_q <= 1'b1;
      if (retire)      retire_q  <= retire_q + CNT_W'(1);
    end
  end

  // Every return to FETCH from another state retires one instruction; FETCH stalls do not.
  assign retire = (state_nxt == S_FETCH) && (state != S_FETCH);

  // Immediate format follows the opcode regardless of state.
  always_comb begin
    imm_src_c = 3'b000;
    case (op)
      OP_SW:   imm_src_c = 3'b001;
      OP_BR:   imm_src_c = 3'b010;
      OP_LUI:  imm_src_c = 3'b011;
      OP_JAL:  imm_src_c = 3'b100;
      default: imm_src_c = 3'b000;
    endcase
  end

  // Next-state and per-state controls.
  always_comb begin
    state_nxt    = state;
    set_illegal  = 1'b0;
    pc_write_c   = 1'b0;
    adr_src_c    = 1'b0;
    mem_req_c    = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    result_src_c = 2'b00;
    alu_src_a_c  = 2'b00;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 2'b00;
    case (state)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        ir_write_c   = ready;
        pc_write_c   = ready;
        if (ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut from OldPC + imm.
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b01;
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECR;
          OP_I:         state_nxt = S_EXECI;
          OP_BR:        state_nxt = S_BRANCH;
          OP_JAL:       state_nxt = S_JAL;
          OP_JALR:      state_nxt = S_JALR;
          OP_LUI:       state_nxt = S_LUI;
          OP_NOP:       state_nxt = S_FETCH;
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              state_nxt   = S_HALT;
              set_illegal = 1'b1;
            end else begin
              state_nxt = S_FETCH;
            end
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        state_nxt   = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        if (ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_c = 2'b01;
        reg_write_c  = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
        if (ready) state_nxt = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a_c = 2'b10;
        alu_op_c    = 2'b10;
        state_nxt   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        alu_op_c    = 2'b10;
        state_nxt   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c = 2'b10;
        alu_op_c    = 2'b01;
        pc_write_c  = zero ^ (BNE_EN & funct3_0);
        state_nxt   = S_FETCH;
      end
      S_JAL: begin
        // PC <- ALUOut (target from DECODE); link value OldPC+4 computed now.
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b10;
        pc_write_c  = 1'b1;
        state_nxt   = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a_c  = 2'b10;
        alu_src_b_c  = 2'b01;
        result_src_c = 2'b10;
        pc_write_c   = 1'b1;
        state_nxt    = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b10;
        state_nxt   = S_ALUWB;
      end
      S_LUI: begin
        result_src_c = 2'b11;
        reg_write_c  = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  // All outputs are held at zero while reset is asserted.
  assign pc_write   = reset_n & pc_write_c;
  assign adr_src    = reset_n & adr_src_c;
  assign mem_req    = reset_n & mem_req_c;
  assign mem_write  = reset_n & mem_write_c;
  assign ir_write   = reset_n & ir_write_c;
  assign reg_write  = reset_n & reg_write_c;
  assign result_src = reset_n ? result_src_c : 2'b00;
  assign alu_src_a  = reset_n ? alu_src_a_c  : 2'b00;
  assign alu_src_b  = reset_n ? alu_src_b_c  : 2'b00;
  assign alu_op     = reset_n ? alu_op_c     : 2'b00;
  assign imm_src    = reset_n ? imm_src_c    : 3'b000;
  assign illegal    = reset_n & illegal_q;
  assign retire_cnt = reset_n ? retire_q     : '0;
  assign state_o    = reset_n ? state        : S_FETCH;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: a table of per-cycle vectors on
// the default configuration, plus hand sequences on a second instance with the
// handshake, bne and trapping disabled and a 3-bit retire counter.
module tb_multicycle_control_fsm;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_NOP  = 7'b0000000;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  op;
  logic        funct3_0, zero, mem_ready;

  logic        pc_write, adr_src, mem_req, mem_write, ir_write, reg_write, illegal;
  logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0]  imm_src;
  logic [31:0] retire_cnt;
  logic [3:0]  state_o;

  logic        b_pc_write, b_adr_src, b_mem_req, b_mem_write, b_ir_write, b_reg_write, b_illegal;
  logic [1:0]  b_result_src, b_alu_src_a, b_alu_src_b, b_alu_op;
  logic [2:0]  b_imm_src;
  logic [2:0]  b_retire_cnt;
  logic [3:0]  b_state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3_0(funct3_0), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src), .mem_req(mem_req),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
    .reg_write(reg_write), .illegal(illegal), .retire_cnt(retire_cnt), .state_o(state_o)
  );

  multicycle_control_fsm #(
    .MEM_HANDSHAKE(1'b0), .BNE_EN(1'b0), .TRAP_ON_ILLEGAL(1'b0), .CNT_W(3)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3_0(funct3_0), .zero(zero),
    .mem_ready(mem_ready), .pc_write(b_pc_write), .adr_src(b_adr_src), .mem_req(b_mem_req),
    .mem_write(b_mem_write), .ir_write(b_ir_write), .result_src(b_result_src),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .imm_src(b_imm_src),
    .reg_write(b_reg_write), .illegal(b_illegal), .retire_cnt(b_retire_cnt), .state_o(b_state_o)
  );

  typedef struct {
    logic        rst_n;
    logic [6:0]  op;
    logic        f3;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] ctl;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  // Expected control word layout matches the concatenation in ctl_now().
  function automatic logic [17:0] c(input logic pw, input logic as_, input logic mr,
                                    input logic mw, input logic iw, input logic [1:0] rs,
                                    input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [1:0] ao, input logic rw, input logic il);
    return {pw, as_, mr, mw, iw, rs, sa, sb, ao, 3'b000, rw, il};
  endfunction

  function automatic logic [17:0] ctl_now();
    return {pc_write, adr_src, mem_req, mem_write, ir_write, result_src, alu_src_a,
            alu_src_b, alu_op, imm_src, reg_write, illegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic [6:0] o, input logic f3, input logic z,
                     input logic rdy, input logic [3:0] st, input logic [17:0] base,
                     input logic [2:0] is, input logic [31:0] cnt);
    vec_t v;
    v.rst_n = rst; v.op = o; v.f3 = f3; v.z = z; v.rdy = rdy; v.st = st;
    v.ctl = base | {13'b0, is, 2'b00};
    v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // Apply inputs just after a rising edge and settle to the falling edge.
  task automatic drive(input logic rst, input logic [6:0] o, input logic f3, input logic z,
                       input logic rdy);
    reset_n = rst; op = o; funct3_0 = f3; zero = z; mem_ready = rdy;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  logic [17:0] k_zero, k_fetch, k_stall, k_dec, k_madr, k_mrd, k_mwb, k_mwr;
  logic [17:0] k_exr, k_exi, k_awb, k_br_t, k_br_n, k_jal, k_jalr, k_jlnk, k_lui, k_halt;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; op = OP_LW; funct3_0 = 1'b0; zero = 1'b0; mem_ready = 1'b1;

    //              pw as mr mw iw rs     sa     sb     ao     rw il
    k_zero  = c(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    k_fetch = c(1, 0, 1, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
    k_stall = c(0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
    k_dec   = c(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0);
    k_madr  = c(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0);
    k_mrd   = c(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    k_mwb   = c(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0);
    k_mwr   = c(0, 1, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    k_exr   = c(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
    k_exi   = c(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0);
    k_awb   = c(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
    k_br_t  = c(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0);
    k_br_n  = c(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0);
    k_jal   = c(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0);
    k_jalr  = c(1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 2'b00, 0, 0);
    k_jlnk  = c(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0);
    k_lui   = c(0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0);
    k_halt  = c(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);

    // rst op f3 z rdy state base imm cnt
    add(0, OP_LW,   0, 0, 1,  0, k_zero,  3'b000,  0);  // reset held 2 cycles
    add(0, OP_LW,   0, 0, 1,  0, k_zero,  3'b000,  0);
    add(1, OP_LW,   0, 0, 1,  0, k_fetch, 3'b000,  0);  // lw: 5 cycles
    add(1, OP_LW,   0, 0, 1,  1, k_dec,   3'b000,  0);
    add(1, OP_LW,   0, 0, 1,  2, k_madr,  3'b000,  0);
    add(1, OP_LW,   0, 0, 1,  3, k_mrd,   3'b000,  0);
    add(1, OP_LW,   0, 0, 1,  4, k_mwb,   3'b000,  0);
    add(1, OP_SW,   0, 0, 1,  0, k_fetch, 3'b001,  1);  // sw with 3 stall cycles
    add(1, OP_SW,   0, 0, 1,  1, k_dec,   3'b001,  1);
    add(1, OP_SW,   0, 0, 1,  2, k_madr,  3'b001,  1);
    add(1, OP_SW,   0, 0, 0,  5, k_mwr,   3'b001,  1);
    add(1, OP_SW,   0, 0, 0,  5, k_mwr,   3'b001,  1);
    add(1, OP_SW,   0, 0, 0,  5, k_mwr,   3'b001,  1);
    add(1, OP_SW,   0, 0, 1,  5, k_mwr,   3'b001,  1);
    add(1, OP_BR,   0, 1, 1,  0, k_fetch, 3'b010,  2);  // beq taken
    add(1, OP_BR,   0, 1, 1,  1, k_dec,   3'b010,  2);
    add(1, OP_BR,   0, 1, 1,  9, k_br_t,  3'b010,  2);
    add(1, OP_BR,   1, 1, 1,  0, k_fetch, 3'b010,  3);  // bne not taken
    add(1, OP_BR,   1, 1, 1,  1, k_dec,   3'b010,  3);
    add(1, OP_BR,   1, 1, 1,  9, k_br_n,  3'b010,  3);
    add(1, OP_JALR, 0, 0, 1,  0, k_fetch, 3'b000,  4);  // jalr: 5 cycles
    add(1, OP_JALR, 0, 0, 1,  1, k_dec,   3'b000,  4);
    add(1, OP_JALR, 0, 0, 1, 11, k_jalr,  3'b000,  4);
    add(1, OP_JALR, 0, 0, 1, 12, k_jlnk,  3'b000,  4);
    add(1, OP_JALR, 0, 0, 1,  8, k_awb,   3'b000,  4);
    add(1, OP_R,    0, 0, 0,  0, k_stall, 3'b000,  5);  // fetch stall, R-type
    add(1, OP_R,    0, 0, 1,  0, k_fetch, 3'b000,  5);
    add(1, OP_R,    0, 0, 1,  1, k_dec,   3'b000,  5);
    add(1, OP_R,    0, 0, 1,  6, k_exr,   3'b000,  5);
    add(1, OP_R,    0, 0, 1,  8, k_awb,   3'b000,  5);
    add(1, OP_I,    0, 0, 1,  0, k_fetch, 3'b000,  6);  // I-ALU
    add(1, OP_I,    0, 0, 1,  1, k_dec,   3'b000,  6);
    add(1, OP_I,    0, 0, 1,  7, k_exi,   3'b000,  6);
    add(1, OP_I,    0, 0, 1,  8, k_awb,   3'b000,  6);
    add(1, OP_JAL,  0, 0, 1,  0, k_fetch, 3'b100,  7);  // jal
    add(1, OP_JAL,  0, 0, 1,  1, k_dec,   3'b100,  7);
    add(1, OP_JAL,  0, 0, 1, 10, k_jal,   3'b100,  7);
    add(1, OP_JAL,  0, 0, 1,  8, k_awb,   3'b100,  7);
    add(1, OP_LUI,  0, 0, 1,  0, k_fetch, 3'b011,  8);  // lui
    add(1, OP_LUI,  0, 0, 1,  1, k_dec,   3'b011,  8);
    add(1, OP_LUI,  0, 0, 1, 13, k_lui,   3'b011,  8);
    add(1, OP_NOP,  0, 0, 1,  0, k_fetch, 3'b000,  9);  // nop
    add(1, OP_NOP,  0, 0, 1,  1, k_dec,   3'b000,  9);
    add(1, OP_BAD,  0, 0, 1,  0, k_fetch, 3'b000, 10);  // illegal traps
    add(1, OP_BAD,  0, 0, 1,  1, k_dec,   3'b000, 10);
    add(1, OP_BAD,  0, 0, 1, 14, k_halt,  3'b000, 10);
    add(1, OP_BAD,  0, 0, 1, 14, k_halt,  3'b000, 10);
    add(0, OP_BAD,  0, 0, 1,  0, k_zero,  3'b000,  0);  // reset clears trap
    add(1, OP_LW,   0, 0, 1,  0, k_fetch, 3'b000,  0);
    add(1, OP_LW,   0, 0, 1,  1, k_dec,   3'b000,  0);
    add(1, OP_LW,   0, 0, 1,  2, k_madr,  3'b000,  0);
    add(0, OP_LW,   0, 0, 0,  0, k_zero,  3'b000,  0);  // reset during MEMREAD
    add(1, OP_LW,   0, 0, 1,  0, k_fetch, 3'b000,  0);
    add(1, OP_LW,   0, 0, 1,  1, k_dec,   3'b000,  0);

    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].op, vecs[i].f3, vecs[i].z, vecs[i].rdy);
      chk($sformatf("v%0d.state", i), 32'(state_o), 32'(vecs[i].st));
      chk($sformatf("v%0d.ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
      chk($sformatf("v%0d.retire", i), retire_cnt, vecs[i].cnt);
      adv();
    end

    // Nine back-to-back lui: 3-bit counter wraps to 1, 32-bit reads 9.
    drive(0, OP_LUI, 0, 0, 1); adv();
    for (int n = 0; n < 27; n++) begin
      drive(1, OP_LUI, 0, 0, 1);
      adv();
    end
    drive(1, OP_LUI, 0, 0, 1);
    chk("lui9.b_retire", 32'(b_retire_cnt), 32'd1);
    chk("lui9.retire", retire_cnt, 32'd9);
    chk("lui9.state", 32'(state_o), 32'd0);

    // No handshake, beq-only: mem_ready low is ignored and bne encoding still takes on zero.
    adv();
    drive(0, OP_BR, 1, 1, 0); adv();
    drive(1, OP_BR, 1, 1, 0);
    chk("nohs.b_fetch_pcw", 32'(b_pc_write), 32'd1);
    chk("nohs.fetch_stall_pcw", 32'(pc_write), 32'd0);
    adv();
    drive(1, OP_BR, 1, 1, 0);
    chk("nohs.b_state_dec", 32'(b_state_o), 32'd1);
    chk("nohs.state_stalled", 32'(state_o), 32'd0);
    adv();
    drive(1, OP_BR, 1, 1, 0);
    chk("beqonly.b_state", 32'(b_state_o), 32'd9);
    chk("beqonly.b_pcw", 32'(b_pc_write), 32'd1);

    // Illegal opcode: nop on the non-trapping instance, HALT on the default one.
    adv();
    drive(0, OP_BAD, 0, 0, 1); adv();
    drive(1, OP_BAD, 0, 0, 1); adv();
    drive(1, OP_BAD, 0, 0, 1); adv();
    drive(1, OP_BAD, 0, 0, 1);
    chk("ill.b_state", 32'(b_state_o), 32'd0);
    chk("ill.b_retire", 32'(b_retire_cnt), 32'd1);
    chk("ill.b_flag", 32'(b_illegal), 32'd0);
    chk("ill.state", 32'(state_o), 32'd14);
    chk("ill.flag", 32'(illegal), 32'd1);
    chk("ill.retire", retire_cnt, 32'd0);
    adv();
    drive(1, OP_BAD, 0, 0, 1);
    chk("ill.halt_memreq", 32'(mem_req), 32'd0);
    chk("ill.halt_state", 32'(state_o), 32'd14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle successor to the single-cycle main decoder: one FSM sequences fetch, decode, execute, memory and writeback over several cycles on a shared datapath (single memory port, IR/OldPC/ALUOut/Data registers).
- Adds a memory ready handshake, optional BNE support, illegal-opcode trapping and a retired-instruction counter.
- Sits in the control unit beside the ALU decoder, which consumes alu_op.

Parameters:
- MEM_HANDSHAKE, 1, 1: memory states wait for mem_ready. 0: mem_ready ignored and treated as 1.
- BNE_EN, 1, 1: funct3_0=1 inverts the branch condition (bne). 0: beq only.
- TRAP_ON_ILLEGAL, 1, 1: an unknown opcode enters HALT. 0: it is a nop and returns to FETCH.
- CNT_W, 32, width of retire_cnt.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- op  in  7  opcode from IR
- funct3_0  in  1  IR bit 12
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory accepted write / read data valid this cycle
- pc_write  out  1  PC register enable (pc_update, or branch taken)
- adr_src  out  1  memory address: 0 PC, 1 ALUOut
- mem_req  out  1  memory access request
- mem_write  out  1  store strobe
- ir_write  out  1  IR and OldPC enable
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1
- alu_src_b  out  2  00 rs2, 01 ImmExt, 10 constant 4
- alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded
- imm_src  out  3  I 000, S 001, B 010, U 011, J 100
- reg_write  out  1  register file write enable
- illegal  out  1  sticky illegal-opcode flag
- retire_cnt  out  CNT_W  retired instruction count
- state_o  out  4  current state (debug)

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALR_LINK, LUI, HALT.
- Outputs are combinational from state. Any signal not listed for a state is 0.
- imm_src is decoded from op in every state: lw/jalr/I-ALU 000, sw 001, branch 010, lui 011, jal 100, else 000.
- "Ready" below means mem_ready=1, or MEM_HANDSHAKE=0.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write and pc_write equal ready. Stay while not ready, else go to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0000000 -> FETCH (nop, retired)
  - other -> HALT with illegal set if TRAP_ON_ILLEGAL, else FETCH (retired)
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Go to MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Hold until ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00. Both strobes are held until ready, then FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, then ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00. pc_write = zero XOR (BNE_EN & funct3_0). Then FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1, then ALUWB.
- JALR: alu_src_a=10, alu_src_b=01, alu_op=00, result_src=10, pc_write=1, then JALR_LINK.
- JALR_LINK: alu_src_a=01, alu_src_b=10, alu_op=00, then ALUWB.
- LUI: result_src=11, reg_write=1, then FETCH.
- HALT: no enables or requests asserted. Stays until reset. illegal=1.
- Cycle counts with ready always 1:
  - lw 5
  - sw 4
  - R, I, jal 4
  - jalr 5
  - branch, lui 3
  - nop/illegal-as-nop 2
- retire_cnt increments by 1 on every transition into FETCH from any state except FETCH. It wraps modulo 2^CNT_W and is unaffected by stalls.
- Reset (reset_n=0 at posedge): state<=FETCH, illegal<=0, retire_cnt<=0. Reset mid-instruction abandons it with no writeback. While reset_n=0, all outputs are forced to 0, including mem_req, pc_write and ir_write. The first FETCH with outputs active is the cycle after release.
- A mem_ready pulse outside a memory state is ignored.

Test Plan:
- Reset held 2 cycles, released, mem_ready=1, op=0000011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 with result_src=01 in cycle 5. retire_cnt=1 after.
- sw with mem_ready low for 3 cycles in MEMWRITE -> mem_write=mem_req=1 held for 4 cycles. FETCH follows the ready cycle. Exactly 1 retire.
- op=1100011: zero=1, funct3_0=0 -> pc_write=1 in BRANCH. zero=1, funct3_0=1 (bne) -> pc_write=0. With BNE_EN=0 and funct3_0=1, zero=1 -> pc_write=1.
- op=1100111 -> JALR shows pc_write=1, alu_src_a=10, alu_src_b=01, result_src=10. JALR_LINK shows alu_src_a=01, alu_src_b=10. ALUWB shows reg_write=1. Total 5 cycles.
- op=1111111 with TRAP_ON_ILLEGAL=1 -> HALT, illegal=1, no further mem_req, retire_cnt unchanged. Reset restores FETCH with illegal=0. With TRAP_ON_ILLEGAL=0 -> FETCH next and retire_cnt+1.
- CNT_W=3: 9 back-to-back lui -> retire_cnt=1 (wrap). reset_n=0 asserted during MEMREAD -> next state FETCH, no reg_write observed.
